// File: rtl/pipeline_job_driver.sv
// pipeline_job_driver
//   Feeds tagged bot jobs into the permutation pipeline and collects its
//   results. The job tag travels through a tag FIFO, is re-attached to each
//   result in issue order, and the result goes out on a valid/ready stream.
//   The shared top vector is only replaced once the pipeline has drained.
//
// Optional feature (macro PCOEFF_ACCUMULATE_EN): adds acc_sum / acc_count,
//   running totals of delivered results, cleared on reset and on top reload.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   top_in, top_load, top_load_done, top
//                                 top replacement request / ack / current top
//   job_bot, job_tag, job_valid, job_ready
//                                 upstream job stream
//   pipe_bot, pipe_write_bot, pipe_ready_for_input_bot
//                                 pipeline bot input side
//   pipe_grab_results, pipe_results_available, pipe_pcoeff_sum,
//   pipe_pcoeff_count, pipe_ecc_status
//                                 pipeline output register side
//   res_valid, res_ready, res_tag, res_pcoeff_sum, res_pcoeff_count, res_ecc
//                                 tagged result stream
//   outstanding, ecc_error_count, underflow_err
//                                 status
//   acc_sum, acc_count            (PCOEFF_ACCUMULATE_EN only) running totals
//
// state | meaning
// IDLE  | no jobs outstanding; jobs or a top reload may start
// RUN   | jobs in flight; new jobs still accepted
// FLUSH | top reload pending; no new jobs, waiting for the pipe to drain
// LOAD  | single cycle: latch top_in, pulse top_load_done

module pipeline_job_driver #(
  parameter int TAG_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [127:0]                         top_in,
  input  logic                                 top_load,
  output logic                                 top_load_done,
  output logic [127:0]                         top,
  input  logic [127:0]                         job_bot,
  input  logic [TAG_WIDTH-1:0]                 job_tag,
  input  logic                                 job_valid,
  output logic                                 job_ready,
  output logic [127:0]                         pipe_bot,
  output logic                                 pipe_write_bot,
  input  logic                                 pipe_ready_for_input_bot,
  output logic                                 pipe_grab_results,
  input  logic                                 pipe_results_available,
  input  logic [47:0]                          pipe_pcoeff_sum,
  input  logic [12:0]                          pipe_pcoeff_count,
  input  logic                                 pipe_ecc_status,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [TAG_WIDTH-1:0]                 res_tag,
  output logic [47:0]                          res_pcoeff_sum,
  output logic [12:0]                          res_pcoeff_count,
  output logic                                 res_ecc,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic [15:0]                          ecc_error_count,
`ifdef PCOEFF_ACCUMULATE_EN
  output logic [63:0]                          acc_sum,
  output logic [31:0]                          acc_count,
`endif
  output logic                                 underflow_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [127:0]         top_q;
  logic [TAG_WIDTH-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 grabbed_q;
  logic                 res_valid_q;
  logic [TAG_WIDTH-1:0] res_tag_q;
  logic [47:0]          res_sum_q;
  logic [12:0]          res_cnt_q;
  logic                 res_ecc_q;
  logic [15:0]          ecc_cnt_q;
  logic                 underflow_q;

  logic accept, grab, pop, fifo_empty, res_hs;

  assign fifo_empty = (cnt_q == '0);

  assign job_ready = pipe_ready_for_input_bot
                   && (cnt_q < CW'(MAX_OUTSTANDING))
                   && ((state_q == S_IDLE) || (state_q == S_RUN))
                   && !top_load;

  assign accept         = job_valid && job_ready;
  assign pipe_write_bot = accept;
  assign pipe_bot       = job_bot;

  // grabbed_q spaces grabs so the pipeline register has a cycle to drop
  // its results_available flag before we look at it again.
  assign grab              = pipe_results_available && !res_valid_q && !grabbed_q;
  assign pipe_grab_results = grab;
  assign pop               = grab && !fifo_empty;
  assign res_hs            = res_valid_q && res_ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (top_load)    state_d = S_LOAD;
        else if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        if (top_load)          state_d = S_FLUSH;
        else if (cnt_d == '0)  state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (fifo_empty && !res_valid_q) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tag storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (accept) tag_mem_q[wr_ptr_q] <= job_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      top_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      grabbed_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_sum_q   <= '0;
      res_cnt_q   <= '0;
      res_ecc_q   <= 1'b0;
      ecc_cnt_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grabbed_q <= grab;
      if (state_q == S_LOAD) top_q <= top_in;
      if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      if (grab) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= pipe_pcoeff_sum;
        res_cnt_q   <= pipe_pcoeff_count;
        res_ecc_q   <= pipe_ecc_status;
        if (fifo_empty) begin
          res_tag_q   <= '0;
          underflow_q <= 1'b1;
        end else begin
          res_tag_q   <= tag_mem_q[rd_ptr_q];
        end
      end else if (res_hs) begin
        res_valid_q <= 1'b0;
      end
      if (res_hs && res_ecc_q && (ecc_cnt_q != 16'hFFFF))
        ecc_cnt_q <= ecc_cnt_q + 16'd1;
    end
  end

`ifdef PCOEFF_ACCUMULATE_EN
  logic [63:0] acc_sum_q;
  logic [31:0] acc_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || (state_q == S_LOAD)) begin
      acc_sum_q <= '0;
      acc_cnt_q <= '0;
    end else if (res_hs) begin
      acc_sum_q <= acc_sum_q + {16'd0, res_sum_q};
      acc_cnt_q <= acc_cnt_q + 32'd1;
    end
  end

  assign acc_sum   = acc_sum_q;
  assign acc_count = acc_cnt_q;
`endif

  assign top_load_done    = (state_q == S_LOAD);
  assign top              = top_q;
  assign res_valid        = res_valid_q;
  assign res_tag          = res_tag_q;
  assign res_pcoeff_sum   = res_sum_q;
  assign res_pcoeff_count = res_cnt_q;
  assign res_ecc          = res_ecc_q;
  assign outstanding      = cnt_q;
  assign ecc_error_count  = ecc_cnt_q;
  assign underflow_err    = underflow_q;

endmodule

// File: tb/tb_pipeline_job_driver.sv
module tb_pipeline_job_driver;
  localparam int TW = 16;
  localparam int MO = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [127:0]  top_in;
  logic          top_load;
  logic          top_load_done;
  logic [127:0]  top;
  logic [127:0]  job_bot;
  logic [TW-1:0] job_tag;
  logic          job_valid;
  logic          job_ready;
  logic [127:0]  pipe_bot;
  logic          pipe_write_bot;
  logic          pipe_ready_for_input_bot;
  logic          pipe_grab_results;
  logic          pipe_results_available;
  logic [47:0]   pipe_pcoeff_sum;
  logic [12:0]   pipe_pcoeff_count;
  logic          pipe_ecc_status;
  logic          res_valid;
  logic          res_ready;
  logic [TW-1:0] res_tag;
  logic [47:0]   res_pcoeff_sum;
  logic [12:0]   res_pcoeff_count;
  logic          res_ecc;
  logic [CW-1:0] outstanding;
  logic [15:0]   ecc_error_count;
  logic          underflow_err;
`ifdef PCOEFF_ACCUMULATE_EN
  logic [63:0]   acc_sum;
  logic [31:0]   acc_count;
`endif

  pipeline_job_driver #(.TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .top_in(top_in), .top_load(top_load), .top_load_done(top_load_done), .top(top),
    .job_bot(job_bot), .job_tag(job_tag), .job_valid(job_valid), .job_ready(job_ready),
    .pipe_bot(pipe_bot), .pipe_write_bot(pipe_write_bot),
    .pipe_ready_for_input_bot(pipe_ready_for_input_bot),
    .pipe_grab_results(pipe_grab_results), .pipe_results_available(pipe_results_available),
    .pipe_pcoeff_sum(pipe_pcoeff_sum), .pipe_pcoeff_count(pipe_pcoeff_count),
    .pipe_ecc_status(pipe_ecc_status),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_pcoeff_sum(res_pcoeff_sum), .res_pcoeff_count(res_pcoeff_count), .res_ecc(res_ecc),
    .outstanding(outstanding), .ecc_error_count(ecc_error_count),
`ifdef PCOEFF_ACCUMULATE_EN
    .acc_sum(acc_sum), .acc_count(acc_count),
`endif
    .underflow_err(underflow_err)
  );

  typedef struct packed {
    logic [15:0] tag;
    logic [47:0] sum;
    logic [12:0] cnt;
    logic        ecc;
  } res_t;

  res_t exp_q[$];
  res_t pipe_q[$];

  int checks = 0;
  int errors = 0;
  int writes_cnt = 0;
  int grab_cnt = 0;
  int done_cnt = 0;
  int delivered = 0;
  bit release_en = 1'b0;
  bit prev_grab = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_bot(input logic [47:0] s, input logic [12:0] c, input logic e);
    return {63'd0, e, 3'd0, c, s};
  endfunction

  // Pipeline model: results derived from the bot actually written; expected
  // results derived from the job offered upstream.
  always @(posedge clk) begin
    res_t r;
    res_t e;
    if (!rst) begin
      pipe_q.delete();
      prev_grab = 1'b0;
      pipe_results_available <= 1'b0;
      pipe_pcoeff_sum        <= '0;
      pipe_pcoeff_count      <= '0;
      pipe_ecc_status        <= 1'b0;
    end else begin
      if (pipe_grab_results) begin
        grab_cnt++;
        chk("grab_spacing", {127'd0, prev_grab}, 128'd0);
        if (pipe_q.size() > 0) void'(pipe_q.pop_front());
      end
      prev_grab = pipe_grab_results;
      if (pipe_write_bot) begin
        writes_cnt++;
        r.tag = '0;
        r.sum = pipe_bot[47:0];
        r.cnt = pipe_bot[60:48];
        r.ecc = pipe_bot[64];
        pipe_q.push_back(r);
        e.tag = job_tag;
        e.sum = job_bot[47:0];
        e.cnt = job_bot[60:48];
        e.ecc = job_bot[64];
        exp_q.push_back(e);
      end
      if (top_load_done) done_cnt++;
      pipe_results_available <= release_en && (pipe_q.size() > 0);
      if (pipe_q.size() > 0) begin
        pipe_pcoeff_sum   <= pipe_q[0].sum;
        pipe_pcoeff_count <= pipe_q[0].cnt;
        pipe_ecc_status   <= pipe_q[0].ecc;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    res_t e;
    res_t a;
    if (rst && res_valid && res_ready) begin
      delivered++;
      a = {res_tag, res_pcoeff_sum, res_pcoeff_count, res_ecc};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got tag 0x%0h sum %0d, nothing expected", res_tag, res_pcoeff_sum);
      end else begin
        e = exp_q.pop_front();
        chk("result", {50'd0, a}, {50'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [127:0] bot, input logic [15:0] tag);
    int n;
    n = 0;
    job_bot = bot;
    job_tag = tag;
    job_valid = 1'b1;
    @(negedge clk);
    while (!job_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag 0x%0h job_ready stayed 0", tag);
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic inject(input logic [47:0] s, input logic [12:0] c);
    res_t r;
    r.tag = '0; r.sum = s; r.cnt = c; r.ecc = 1'b0;
    pipe_q.push_back(r);
    exp_q.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(outstanding == 0 && !res_valid && pipe_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", name}, {127'd0, (n >= 2000)}, 128'd0);
    chk({"exp_empty_", name}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!top_load_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({"load_done_", name}, {127'd0, top_load_done}, 128'd1);
  endtask

`ifdef PCOEFF_ACCUMULATE_EN
  task automatic do_top_load(input logic [127:0] v);
    step();
    top_in = v;
    top_load = 1'b1;
    wait_done("acc");
    step();
    top_load = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, g0, r0;
    bit jr_seen;
    rst = 1'b0;
    top_in = '0;
    top_load = 1'b0;
    job_bot = '0;
    job_tag = '0;
    job_valid = 1'b0;
    pipe_ready_for_input_bot = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outstanding", 128'(outstanding), 128'd0);
    chk("rst_res_valid", {127'd0, res_valid}, 128'd0);
    chk("rst_top", top, 128'd0);
    chk("rst_underflow", {127'd0, underflow_err}, 128'd0);
    chk("rst_ecc_count", 128'(ecc_error_count), 128'd0);
    chk("rst_job_ready", {127'd0, job_ready}, 128'd0);
    chk("rst_load_done", {127'd0, top_load_done}, 128'd0);
    step();
    rst = 1'b1;
    pipe_ready_for_input_bot = 1'b1;

    // three jobs, in-order tagged results
    w0 = writes_cnt;
    r0 = delivered;
    send_job(mk_bot(48'd5, 13'd1, 1'b0), 16'h11);
    send_job(mk_bot(48'd10, 13'd2, 1'b0), 16'h22);
    send_job(mk_bot(48'd15, 13'd3, 1'b0), 16'h33);
    @(negedge clk);
    chk("p1_outstanding", 128'(outstanding), 128'd3);
    chk("p1_writes", 128'(writes_cnt - w0), 128'd3);
    step();
    res_ready = 1'b1;
    release_en = 1'b1;
    wait_drain("p1");
    chk("p1_delivered", 128'(delivered - r0), 128'd3);

    // fill to MAX_OUTSTANDING, then one grab with res_ready low
    step();
    release_en = 1'b0;
    res_ready = 1'b0;
    r0 = delivered;
    for (int i = 0; i < MO; i++)
      send_job(mk_bot(48'(i + 1), 13'(i), 1'b0), 16'(16'h100 + i));
    @(negedge clk);
    chk("p2_full_outstanding", 128'(outstanding), 128'd32);
    chk("p2_full_job_ready", {127'd0, job_ready}, 128'd0);
    g0 = grab_cnt;
    step();
    release_en = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!pipe_grab_results && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("p2_grab_seen", {127'd0, pipe_grab_results}, 128'd1);
    end
    @(negedge clk);
    chk("p2_job_ready_after_grab", {127'd0, job_ready}, 128'd1);
    chk("p2_outstanding_31", 128'(outstanding), 128'd31);
    chk("p2_res_valid", {127'd0, res_valid}, 128'd1);
    repeat (6) @(negedge clk);
    chk("p2_single_grab", 128'(grab_cnt - g0), 128'd1);
    step();
    res_ready = 1'b1;
    wait_drain("p2");
    chk("p2_delivered", 128'(delivered - r0), 128'd32);

    // top_load with two jobs outstanding
    step();
    release_en = 1'b0;
    send_job(mk_bot(48'd7, 13'd4, 1'b0), 16'h44);
    send_job(mk_bot(48'd8, 13'd5, 1'b0), 16'h55);
    step();
    top_in = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
    top_load = 1'b1;
    @(negedge clk);
    chk("p3_job_ready_blocked", {127'd0, job_ready}, 128'd0);
    chk("p3_outstanding", 128'(outstanding), 128'd2);
    d0 = done_cnt;
    step();
    release_en = 1'b1;
    jr_seen = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!top_load_done && n < 2000) begin
        if (job_ready) jr_seen = 1'b1;
        @(negedge clk);
        n++;
      end
      chk("p3_load_done", {127'd0, top_load_done}, 128'd1);
    end
    chk("p3_no_job_ready_in_flush", {127'd0, jr_seen}, 128'd0);
    chk("p3_drained_outstanding", 128'(outstanding), 128'd0);
    chk("p3_drained_res_valid", {127'd0, res_valid}, 128'd0);
    chk("p3_top_before_load", top, 128'd0);
    step();
    top_load = 1'b0;
    @(negedge clk);
    chk("p3_top", top, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
    chk("p3_done_pulses", 128'(done_cnt - d0), 128'd1);
    chk("p3_done_low", {127'd0, top_load_done}, 128'd0);
    chk("p3_idle_job_ready", {127'd0, job_ready}, 128'd1);
    chk("p3_exp_empty", 128'(exp_q.size()), 128'd0);

    // ECC result, then underflow injection
    step();
    release_en = 1'b0;
    send_job(mk_bot(48'd3, 13'd1, 1'b1), 16'h66);
    step();
    release_en = 1'b1;
    wait_drain("ecc");
    chk("ecc_count", 128'(ecc_error_count), 128'd1);
    chk("no_underflow_yet", {127'd0, underflow_err}, 128'd0);
    step();
    inject(48'h1234, 13'd2);
    wait_drain("underflow");
    chk("underflow_err", {127'd0, underflow_err}, 128'd1);
    chk("underflow_outstanding", 128'(outstanding), 128'd0);
    chk("ecc_count_unchanged", 128'(ecc_error_count), 128'd1);

`ifdef PCOEFF_ACCUMULATE_EN
    do_top_load(128'h5);
    @(negedge clk);
    chk("acc_sum_cleared", acc_sum, 128'd0);
    chk("acc_count_cleared", 128'(acc_count), 128'd0);
    step();
    release_en = 1'b0;
    send_job(mk_bot(48'd100, 13'd1, 1'b0), 16'h77);
    send_job(mk_bot(48'd200, 13'd1, 1'b0), 16'h88);
    step();
    release_en = 1'b1;
    wait_drain("acc");
    chk("acc_sum", 128'(acc_sum), 128'd300);
    chk("acc_count", 128'(acc_count), 128'd2);
    do_top_load(128'h6);
    @(negedge clk);
    chk("acc_sum_after_load", 128'(acc_sum), 128'd0);
    chk("acc_count_after_load", 128'(acc_count), 128'd0);
`endif

    repeat (4) @(negedge clk);
    chk("final_exp_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
